// File: rtl/elevator_pkg.sv
// Shared types, default timing constants and SCAN direction-mask helpers
// for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  localparam int DEF_TRAVEL_CYC = 4;
  localparam int DEF_DOOR_CYC   = 3;
  localparam int MAX_FLOORS     = 32;

  // Pending floors strictly beyond cur in the given sweep direction.
  function automatic logic [MAX_FLOORS-1:0] ahead_mask(
    input logic [MAX_FLOORS-1:0] pend,
    input int                    cur,
    input logic                  up
  );
    ahead_mask = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (up ? (i > cur) : (i < cur)) ahead_mask[i] = pend[i];
    end
  endfunction

  function automatic logic [MAX_FLOORS-1:0] behind_mask(
    input logic [MAX_FLOORS-1:0] pend,
    input int                    cur,
    input logic                  up
  );
    behind_mask = ahead_mask(pend, cur, ~up);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter; done_o flags the final cycle of a LOAD_VAL-cycle interval.
module elevator_timer #(
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);
  localparam int W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load_i)         cnt_q <= W'(LOAD_VAL);
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: request latch, IDLE/MOVING/DOOR FSM and
// registered move/door strobes.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = 3,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int DOOR_CYC   = DEF_DOOR_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_FLOORS-1:0]         req,
  output logic [$clog2(N_FLOORS)-1:0] floor,
  output logic                        dir_up,
  output logic                        move_up,
  output logic                        move_down,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        idle
);
  localparam int FW = $clog2(N_FLOORS);

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d, floor_step;
  logic                dir_q, dir_d;
  logic [N_FLOORS-1:0] pend_q, pend_d;
  logic                move_up_q, move_down_q, door_q, idle_q;
  logic                travel_load, travel_done, door_load, door_done;
  logic                any_ahead, any_behind, restart;

  elevator_timer #(.LOAD_VAL(TRAVEL_CYC)) u_travel_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (travel_load),
    .done_o (travel_done)
  );

  elevator_timer #(.LOAD_VAL(DOOR_CYC)) u_door_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (door_load),
    .done_o (door_done)
  );

  assign any_ahead  = |ahead_mask(MAX_FLOORS'(pend_q), int'(floor_q), dir_q);
  assign any_behind = |behind_mask(MAX_FLOORS'(pend_q), int'(floor_q), dir_q);
  assign floor_step = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
  assign restart    = (state_q == DOOR) && req[floor_q];

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    pend_d      = pend_q | req;
    travel_load = 1'b0;
    door_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q[floor_q]) begin
          state_d = DOOR;
        end else if (any_ahead) begin
          state_d = MOVING;
        end else if (any_behind) begin
          dir_d   = ~dir_q;
          state_d = MOVING;
        end
      end
      MOVING: begin
        if (travel_done) begin
          floor_d = floor_step;
          if (pend_q[floor_step]) state_d = DOOR;
          else                    travel_load = 1'b1;
        end
      end
      DOOR: begin
        if (restart) begin
          door_load = 1'b1;
        end else if (door_done) begin
          if (any_ahead) begin
            state_d = MOVING;
          end else if (any_behind) begin
            dir_d   = ~dir_q;
            state_d = MOVING;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // A call at the floor being served is absorbed by the open door.
    if (state_q == DOOR) pend_d[floor_q] = pend_q[floor_q];
    if (state_d == DOOR && state_q != DOOR) begin
      pend_d[floor_d] = 1'b0;
      door_load       = 1'b1;
    end
    if (state_d == MOVING && state_q != MOVING) travel_load = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      pend_q      <= '0;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
      door_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      move_up_q   <= (state_d == MOVING) && dir_d;
      move_down_q <= (state_d == MOVING) && !dir_d;
      door_q      <= (state_d == DOOR);
      idle_q      <= (state_d == IDLE);
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_q;
  assign move_up   = move_up_q;
  assign move_down = move_down_q;
  assign door_open = door_q;
  assign pending   = pend_q;
  assign idle      = idle_q;

endmodule
